cp0_exc_sequencer: RTL

- Owns the CP0 architectural registers: BadVAddr, Count, Compare, Status, Cause and EPC.
- Sequences exception, interrupt and ERET commits at the WB stage.
- Before redirecting fetch, it stalls WB and waits for outstanding AXI transactions to drain. It then issues a one-cycle flush and redirect PC.
- Sits beside the WB stage and consumes the WB-stage exception summary produced by the CP0 decode logic.

---
 rtl/cp0_exc_sequencer_if.sv | 38 +++
 rtl/cp0_exc_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_sequencer_if.sv
// WB-side bundle for the CP0 exception sequencer: commit inputs, MTC0/MFC0
// access, AXI drain status and the stall/flush/redirect controls.
interface cp0_exc_sequencer_if;
   // WB holds its instruction while stall_wb=1; an instruction with
   // wb_valid=1 in a cycle with stall_wb=0 has retired. Any commit event ends
   // with exactly one flush cycle, and redirect_pc is meaningful only then.
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic        wb_bd;
   logic        wb_exc;
   logic [4:0]  wb_exccode;
   logic [31:0] wb_badvaddr;
   logic        wb_badv_we;
   logic        wb_eret;
   logic        mtc0_we;
   logic [4:0]  c0_addr;
   logic [31:0] c0_wdata;
   logic [31:0] c0_rdata;
   logic [5:0]  hw_int;
   logic        axi_busy;
   logic        stall_wb;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        int_pending;
   logic [1:0]  state_dbg;

   modport master (
      output wb_valid, wb_pc, wb_bd, wb_exc, wb_exccode, wb_badvaddr, wb_badv_we,
      output wb_eret, mtc0_we, c0_addr, c0_wdata, hw_int, axi_busy,
      input  c0_rdata, stall_wb, flush, redirect_pc, int_pending, state_dbg
   );

   modport slave (
      input  wb_valid, wb_pc, wb_bd, wb_exc, wb_exccode, wb_badvaddr, wb_badv_we,
      input  wb_eret, mtc0_we, c0_addr, c0_wdata, hw_int, axi_busy,
      output c0_rdata, stall_wb, flush, redirect_pc, int_pending, state_dbg
   );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// CP0 register file plus the WB-stage exception/interrupt/ERET commit
// sequencer: stall, drain AXI, then a single flush cycle with a redirect PC.
module cp0_exc_sequencer #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
   parameter int          COUNT_DIV = 2
) (
   input logic               clk,
   input logic               resetn,
   cp0_exc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_STATUS   = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;

   localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   state_t state, next_state;

   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic        cause_bd;
   logic        cause_ti;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_exccode;
   logic [31:0] epc;
   logic [DIV_W-1:0] div_cnt;
   logic        match_q;

   logic        lat_eret;
   logic [31:0] lat_pc;
   logic        lat_bd;
   logic [4:0]  lat_code;
   logic [31:0] lat_badvaddr;
   logic        lat_badv_we;

   logic [31:0] status_word;
   logic [31:0] cause_word;
   logic        int_pending;
   logic        trig;
   logic        mtc0_ok;
   logic        commit_exc;
   logic        commit_eret;
   logic        match;
   logic        flush;
   logic [31:0] redirect_pc;

   assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                         1'b0, cause_exccode, 2'b00};

   assign int_pending = status_ie & ~status_exl &
                        (|({cause_ip_hw, cause_ip_sw} & status_im));
   assign trig        = (state == IDLE) & bus.wb_valid &
                        (bus.wb_exc | int_pending | bus.wb_eret);
   // Writes on a trigger cycle belong to an instruction that is being flushed.
   assign mtc0_ok     = bus.mtc0_we & (state == IDLE) & ~trig;
   assign commit_exc  = (state == COMMIT) & ~lat_eret;
   assign commit_eret = (state == COMMIT) & lat_eret;
   assign match       = (count == compare);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (trig) next_state = bus.axi_busy ? DRAIN : COMMIT;
         DRAIN:   if (!bus.axi_busy) next_state = COMMIT;
         COMMIT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      flush       = 1'b0;
      redirect_pc = 32'd0;
      if (state == COMMIT) begin
         flush       = 1'b1;
         redirect_pc = lat_eret ? epc : EXC_ENTRY;
      end
   end

   assign bus.flush       = flush;
   assign bus.redirect_pc = redirect_pc;
   assign bus.stall_wb    = trig | (state != IDLE);
   assign bus.int_pending = int_pending;
   assign bus.state_dbg   = state;

   // Commit context; an interrupt takes priority and suppresses the instruction.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lat_eret     <= 1'b0;
         lat_pc       <= 32'd0;
         lat_bd       <= 1'b0;
         lat_code     <= 5'd0;
         lat_badvaddr <= 32'd0;
         lat_badv_we  <= 1'b0;
      end else if (trig) begin
         lat_pc       <= bus.wb_pc;
         lat_bd       <= bus.wb_bd;
         lat_badvaddr <= bus.wb_badvaddr;
         if (int_pending) begin
            lat_eret    <= 1'b0;
            lat_code    <= 5'd0;
            lat_badv_we <= 1'b0;
         end else if (bus.wb_exc) begin
            lat_eret    <= 1'b0;
            lat_code    <= bus.wb_exccode;
            lat_badv_we <= bus.wb_badv_we;
         end else begin
            lat_eret    <= 1'b1;
            lat_code    <= 5'd0;
            lat_badv_we <= 1'b0;
         end
      end
   end

   // Count with its prescaler; a software write restarts the prescaler.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count   <= 32'd0;
         div_cnt <= '0;
      end else if (mtc0_ok && bus.c0_addr == ADDR_COUNT) begin
         count   <= bus.c0_wdata;
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         count   <= count + 32'd1;
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Count==Compare already holds out of reset, so it is not a new match.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         compare  <= 32'd0;
         cause_ti <= 1'b0;
         match_q  <= 1'b1;
      end else begin
         match_q <= match;
         if (mtc0_ok && bus.c0_addr == ADDR_COMPARE) begin
            compare  <= bus.c0_wdata;
            cause_ti <= 1'b0;
         end else if (match && !match_q) begin
            cause_ti <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_im  <= 8'd0;
         status_exl <= 1'b0;
         status_ie  <= 1'b0;
      end else if (commit_exc) begin
         status_exl <= 1'b1;
      end else if (commit_eret) begin
         status_exl <= 1'b0;
      end else if (mtc0_ok && bus.c0_addr == ADDR_STATUS) begin
         status_im  <= bus.c0_wdata[15:8];
         status_exl <= bus.c0_wdata[1];
         status_ie  <= bus.c0_wdata[0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cause_bd      <= 1'b0;
         cause_ip_hw   <= 6'd0;
         cause_ip_sw   <= 2'd0;
         cause_exccode <= 5'd0;
      end else begin
         cause_ip_hw <= {bus.hw_int[5] | cause_ti, bus.hw_int[4:0]};
         if (commit_exc) begin
            cause_exccode <= lat_code;
            if (!status_exl) cause_bd <= lat_bd;
         end else if (mtc0_ok && bus.c0_addr == ADDR_CAUSE) begin
            cause_ip_sw <= bus.c0_wdata[9:8];
         end
      end
   end

   // A nested exception (EXL already set) keeps the original return address.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         epc <= 32'd0;
      end else if (commit_exc) begin
         if (!status_exl) epc <= lat_bd ? (lat_pc - 32'd4) : lat_pc;
      end else if (mtc0_ok && bus.c0_addr == ADDR_EPC) begin
         epc <= bus.c0_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        badvaddr <= 32'd0;
      else if (commit_exc && lat_badv_we) badvaddr <= lat_badvaddr;
   end

   always_comb begin
      bus.c0_rdata = 32'd0;
      case (bus.c0_addr)
         ADDR_BADVADDR: bus.c0_rdata = badvaddr;
         ADDR_COUNT:    bus.c0_rdata = count;
         ADDR_COMPARE:  bus.c0_rdata = compare;
         ADDR_STATUS:   bus.c0_rdata = status_word;
         ADDR_CAUSE:    bus.c0_rdata = cause_word;
         ADDR_EPC:      bus.c0_rdata = epc;
         default:       bus.c0_rdata = 32'd0;
      endcase
   end

endmodule
